// File: rtl/controle_rega.sv
// Irrigation controller: primes the pump, runs a drip or sprinkler cycle, rests,
// and latches a fault on water-level alarm until the operator acknowledges it.
module controle_rega #(
    parameter int DIV           = 4,
    parameter int T_PARTIDA     = 2,
    parameter int T_GOTEJAMENTO = 10,
    parameter int T_ASPERSAO    = 6,
    parameter int T_PAUSA       = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic       alarme,
    input  logic       gotejamento,
    input  logic       aspersao,
    input  logic       reconhece,
    output logic       bomba,
    output logic       valvulaGotejamento,
    output logic       valvulaAspersao,
    output logic       alarmeSaida,
    output logic [2:0] estado,
    output logic [7:0] ciclos
);

    typedef enum logic [2:0] {
        OCIOSO     = 3'd0,
        PARTIDA    = 3'd1,
        GOTEJANDO  = 3'd2,
        ASPERSANDO = 3'd3,
        PAUSA      = 3'd4,
        FALHA      = 3'd5
    } estado_t;

    localparam logic [7:0] DIV_MAX       = 8'(DIV - 1);
    localparam logic [7:0] FIM_PARTIDA   = 8'(T_PARTIDA - 1);
    localparam logic [7:0] FIM_GOTEJAR   = 8'(T_GOTEJAMENTO - 1);
    localparam logic [7:0] FIM_ASPERSAO  = 8'(T_ASPERSAO - 1);
    localparam logic [7:0] FIM_PAUSA     = 8'(T_PAUSA - 1);

    estado_t    estadoAtual;
    estado_t    proximoEstado;
    logic [7:0] prescaler;
    logic [7:0] timer;
    logic [7:0] ciclosReg;
    logic       modoAspersao;
    logic       proximoModo;
    logic       incrementa;
    logic       fimTick;

    assign fimTick = (prescaler == DIV_MAX);

    // Alarm has top priority in every non-fault state, even over a timer expiry
    // landing on the same edge; expiry beats a simultaneous request drop so the
    // cycle is still credited.
    always_comb begin
        proximoEstado = estadoAtual;
        proximoModo   = modoAspersao;
        incrementa    = 1'b0;
        case (estadoAtual)
            OCIOSO: begin
                if (alarme) begin
                    proximoEstado = FALHA;
                end else if (habilita && aspersao) begin
                    proximoEstado = PARTIDA;
                    proximoModo   = 1'b1;
                end else if (habilita && gotejamento) begin
                    proximoEstado = PARTIDA;
                    proximoModo   = 1'b0;
                end
            end
            PARTIDA: begin
                if (alarme) begin
                    proximoEstado = FALHA;
                end else if (fimTick && timer == FIM_PARTIDA) begin
                    proximoEstado = modoAspersao ? ASPERSANDO : GOTEJANDO;
                end
            end
            GOTEJANDO: begin
                if (alarme) begin
                    proximoEstado = FALHA;
                end else if (fimTick && timer == FIM_GOTEJAR) begin
                    proximoEstado = PAUSA;
                    incrementa    = 1'b1;
                end else if (!gotejamento || !habilita) begin
                    proximoEstado = PAUSA;
                end
            end
            ASPERSANDO: begin
                if (alarme) begin
                    proximoEstado = FALHA;
                end else if (fimTick && timer == FIM_ASPERSAO) begin
                    proximoEstado = PAUSA;
                    incrementa    = 1'b1;
                end else if (!aspersao || !habilita) begin
                    proximoEstado = PAUSA;
                end
            end
            PAUSA: begin
                if (alarme) begin
                    proximoEstado = FALHA;
                end else if (fimTick && timer == FIM_PAUSA) begin
                    proximoEstado = OCIOSO;
                end
            end
            FALHA: begin
                if (!alarme && reconhece) begin
                    proximoEstado = PAUSA;
                end
            end
            default: proximoEstado = OCIOSO;
        endcase
    end

    // Timebase restarts on every state change so each timed state starts from zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estadoAtual  <= OCIOSO;
            modoAspersao <= 1'b0;
            prescaler    <= 8'd0;
            timer        <= 8'd0;
            ciclosReg    <= 8'd0;
        end else begin
            estadoAtual  <= proximoEstado;
            modoAspersao <= proximoModo;
            if (proximoEstado != estadoAtual) begin
                prescaler <= 8'd0;
                timer     <= 8'd0;
            end else if (fimTick) begin
                prescaler <= 8'd0;
                timer     <= timer + 8'd1;
            end else begin
                prescaler <= prescaler + 8'd1;
            end
            if (incrementa && ciclosReg != 8'hFF) begin
                ciclosReg <= ciclosReg + 8'd1;
            end
        end
    end

    assign bomba              = (estadoAtual == PARTIDA) || (estadoAtual == GOTEJANDO) ||
                                (estadoAtual == ASPERSANDO);
    assign valvulaGotejamento = (estadoAtual == GOTEJANDO);
    assign valvulaAspersao    = (estadoAtual == ASPERSANDO);
    assign alarmeSaida        = (estadoAtual == FALHA);
    assign estado             = estadoAtual;
    assign ciclos             = ciclosReg;

endmodule

// File: tb/tb_controle_rega.sv
// Scoreboard bench for controle_rega: expected state visits are queued by the
// stimulus and popped by a negedge monitor whenever the DUT changes state.
module tb_controle_rega;

    localparam logic [2:0] S_OCIOSO = 3'd0;
    localparam logic [2:0] S_PART   = 3'd1;
    localparam logic [2:0] S_GOT    = 3'd2;
    localparam logic [2:0] S_ASP    = 3'd3;
    localparam logic [2:0] S_PAUSA  = 3'd4;
    localparam logic [2:0] S_FALHA  = 3'd5;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilita, alarme, gotejamento, aspersao, reconhece;
    logic       bomba, valvulaGotejamento, valvulaAspersao, alarmeSaida;
    logic [2:0] estado;
    logic [7:0] ciclos;

    typedef struct {
        string      nome;
        logic [2:0] est;
        logic [3:0] saidas;
        logic [7:0] cic;
        int         dur;
    } item_t;

    item_t transQ[$];
    item_t spotQ[$];
    item_t atual;
    int    checks = 0;
    int    errors = 0;
    int    ocup   = 0;
    event  spotEvt;

    controle_rega #(
        .DIV(4), .T_PARTIDA(2), .T_GOTEJAMENTO(10), .T_ASPERSAO(6), .T_PAUSA(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .habilita(habilita),
        .alarme(alarme),
        .gotejamento(gotejamento),
        .aspersao(aspersao),
        .reconhece(reconhece),
        .bomba(bomba),
        .valvulaGotejamento(valvulaGotejamento),
        .valvulaAspersao(valvulaAspersao),
        .alarmeSaida(alarmeSaida),
        .estado(estado),
        .ciclos(ciclos)
    );

    always #5 clock = ~clock;

    // Drive order {bomba, valvulaGotejamento, valvulaAspersao, alarmeSaida}.
    function automatic logic [3:0] decode(input logic [2:0] e);
        case (e)
            S_PART:  return 4'b1000;
            S_GOT:   return 4'b1100;
            S_ASP:   return 4'b1010;
            S_FALHA: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic item_t mk(input string n, input logic [2:0] e, input int c, input int d);
        item_t it;
        it.nome   = n;
        it.est    = e;
        it.saidas = decode(e);
        it.cic    = 8'(c);
        it.dur    = d;
        return it;
    endfunction

    task automatic esperar(input string n, input logic [2:0] e, input int c, input int d);
        transQ.push_back(mk(n, e, c, d));
    endtask

    task automatic applyStimulus(input logic hab, input logic alm, input logic got,
                                 input logic asp, input logic rec);
        habilita    = hab;
        alarme      = alm;
        gotejamento = got;
        aspersao    = asp;
        reconhece   = rec;
    endtask

    task automatic checkOutput(input string nome, input logic [31:0] obtido,
                               input logic [31:0] exigido);
        checks++;
        if (obtido !== exigido) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", nome, obtido, exigido);
        end
    endtask

    task automatic waitState(input logic [2:0] alvo, input int limite, input string nome);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (estado !== alvo && n < limite);
        if (estado !== alvo) checkOutput({nome, "_timeout"}, 32'(estado), 32'(alvo));
    endtask

    // Each state change consumes one queued visit; occupancy of the state being
    // left is checked against the duration recorded for it.
    always @(negedge clock) begin
        if (estado !== atual.est) begin
            if (atual.dur >= 0) checkOutput({atual.nome, "_dur"}, 32'(ocup), 32'(atual.dur));
            if (transQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL transicao_inesperada: got estado %0d, required %0d", estado, atual.est);
                atual = mk("inesperado", estado, 0, -1);
            end else begin
                atual = transQ.pop_front();
                checkOutput({atual.nome, "_estado"}, 32'(estado), 32'(atual.est));
            end
            ocup = 0;
        end
        ocup++;
        checkOutput({atual.nome, "_saidas"},
                    32'({bomba, valvulaGotejamento, valvulaAspersao, alarmeSaida}),
                    32'(atual.saidas));
        checkOutput({atual.nome, "_ciclos"}, 32'(ciclos), 32'(atual.cic));
    end

    always @(spotEvt) begin : spotMon
        item_t s;
        if (spotQ.size() != 0) begin
            s = spotQ.pop_front();
            checkOutput({s.nome, "_estado"}, 32'(estado), 32'(s.est));
            checkOutput({s.nome, "_saidas"},
                        32'({bomba, valvulaGotejamento, valvulaAspersao, alarmeSaida}),
                        32'(s.saidas));
            checkOutput({s.nome, "_ciclos"}, 32'(ciclos), 32'(s.cic));
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        atual = mk("reset", S_OCIOSO, 0, -1);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        #1;
        spotQ.push_back(mk("reset_inicial", S_OCIOSO, 0, -1));
        ->spotEvt;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Drip cycle, full length
        esperar("s1_partida", S_PART, 0, 8);
        esperar("s1_gotejando", S_GOT, 0, 40);
        esperar("s1_pausa", S_PAUSA, 1, 12);
        esperar("s1_ocioso", S_OCIOSO, 1, -1);
        applyStimulus(1, 0, 1, 0, 0);
        waitState(S_PAUSA, 100, "s1");
        applyStimulus(1, 0, 0, 0, 0);
        waitState(S_OCIOSO, 50, "s1_fim");
        repeat (3) @(negedge clock);

        // Both requests: sprinkler wins
        esperar("s2_partida", S_PART, 1, 8);
        esperar("s2_aspersando", S_ASP, 1, 24);
        esperar("s2_pausa", S_PAUSA, 2, 12);
        esperar("s2_ocioso", S_OCIOSO, 2, -1);
        applyStimulus(1, 0, 1, 1, 0);
        waitState(S_PAUSA, 100, "s2");
        applyStimulus(0, 0, 0, 0, 0);
        waitState(S_OCIOSO, 50, "s2_fim");
        repeat (3) @(negedge clock);

        // One-cycle alarm pulse at cycle 20 of drip, then acknowledge
        esperar("s3_partida", S_PART, 2, 8);
        esperar("s3_gotejando", S_GOT, 2, 20);
        esperar("s3_falha", S_FALHA, 2, 4);
        esperar("s3_pausa", S_PAUSA, 2, 12);
        esperar("s3_ocioso", S_OCIOSO, 2, -1);
        applyStimulus(1, 0, 1, 0, 0);
        waitState(S_GOT, 50, "s3");
        repeat (19) @(negedge clock);
        applyStimulus(1, 1, 1, 0, 0);
        @(negedge clock);
        applyStimulus(1, 0, 0, 0, 0);
        repeat (3) @(negedge clock);
        applyStimulus(1, 0, 0, 0, 1);
        @(negedge clock);
        applyStimulus(1, 0, 0, 0, 0);
        waitState(S_OCIOSO, 50, "s3_fim");
        repeat (3) @(negedge clock);

        // Drip request dropped at cycle 10: early rest, no credit
        esperar("s4_partida", S_PART, 2, 8);
        esperar("s4_gotejando", S_GOT, 2, 10);
        esperar("s4_pausa", S_PAUSA, 2, 12);
        esperar("s4_ocioso", S_OCIOSO, 2, -1);
        applyStimulus(1, 0, 1, 0, 0);
        waitState(S_GOT, 50, "s4");
        repeat (9) @(negedge clock);
        applyStimulus(1, 0, 0, 0, 0);
        waitState(S_OCIOSO, 50, "s4_fim");
        repeat (3) @(negedge clock);

        // Alarm on the same edge as drip expiry: fault wins, no credit
        esperar("s5_partida", S_PART, 2, 8);
        esperar("s5_gotejando", S_GOT, 2, 40);
        esperar("s5_falha", S_FALHA, 2, 1);
        esperar("s5_pausa", S_PAUSA, 2, 12);
        esperar("s5_ocioso", S_OCIOSO, 2, -1);
        applyStimulus(1, 0, 1, 0, 0);
        waitState(S_GOT, 50, "s5");
        repeat (39) @(negedge clock);
        applyStimulus(1, 1, 1, 0, 0);
        @(negedge clock);
        applyStimulus(1, 0, 0, 0, 1);
        @(negedge clock);
        applyStimulus(1, 0, 0, 0, 0);
        waitState(S_OCIOSO, 50, "s5_fim");
        repeat (3) @(negedge clock);

        // Acknowledge ignored while alarm still high
        esperar("s6_falha", S_FALHA, 2, 3);
        esperar("s6_pausa", S_PAUSA, 2, 12);
        esperar("s6_ocioso", S_OCIOSO, 2, -1);
        applyStimulus(0, 1, 0, 0, 0);
        @(negedge clock);
        applyStimulus(0, 1, 0, 0, 1);
        repeat (2) @(negedge clock);
        applyStimulus(0, 0, 0, 0, 1);
        @(negedge clock);
        applyStimulus(0, 0, 0, 0, 0);
        waitState(S_OCIOSO, 50, "s6_fim");
        repeat (3) @(negedge clock);

        // Asynchronous reset in the middle of a sprinkler cycle
        esperar("s7_partida", S_PART, 2, 8);
        esperar("s7_aspersando", S_ASP, 2, -1);
        esperar("s7_ocioso", S_OCIOSO, 0, -1);
        applyStimulus(1, 0, 0, 1, 0);
        waitState(S_ASP, 50, "s7");
        repeat (5) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        spotQ.push_back(mk("s7_reset_assincrono", S_OCIOSO, 0, -1));
        ->spotEvt;
        applyStimulus(0, 0, 0, 0, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // 256 back-to-back sprinkler cycles: counter saturates at 255
        for (int i = 0; i < 256; i++) begin
            esperar($sformatf("s8_partida_%0d", i), S_PART, i, 8);
            esperar($sformatf("s8_aspersando_%0d", i), S_ASP, i, 24);
            esperar($sformatf("s8_pausa_%0d", i), S_PAUSA, (i + 1 > 255) ? 255 : i + 1, 12);
            esperar($sformatf("s8_ocioso_%0d", i), S_OCIOSO, (i + 1 > 255) ? 255 : i + 1,
                    (i == 255) ? -1 : 1);
        end
        applyStimulus(1, 0, 0, 1, 0);
        for (int i = 0; i < 256; i++) begin
            waitState(S_ASP, 50, "s8_asp");
            waitState(S_PAUSA, 50, "s8_pausa");
        end
        applyStimulus(0, 0, 0, 0, 0);
        waitState(S_OCIOSO, 50, "s8_fim");
        repeat (5) @(negedge clock);

        checkOutput("fila_pendente", 32'(transQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/controle_rega.md
CONTROLE_REGA -- requirements
Module: controle_rega

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DIV  4  clock cycles per time tick (2..255)
  T_PARTIDA  2  pump priming duration, ticks (1..255)
  T_GOTEJAMENTO  10  drip cycle duration, ticks (1..255)
  T_ASPERSAO  6  sprinkler cycle duration, ticks (1..255)
  T_PAUSA  3  post-cycle rest duration, ticks (1..255)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clock  in  1  single system clock, rising edge
  reset  in  1  asynchronous, active-high reset
  habilita  in  1  controller enable
  alarme  in  1  water-level alarm from the irrigation-type decoder
  gotejamento  in  1  drip request from the decoder
  aspersao  in  1  sprinkler request from the decoder
  reconhece  in  1  operator alarm acknowledge, level-sampled
  bomba  out  1  pump drive
  valvulaGotejamento  out  1  drip valve drive
  valvulaAspersao  out  1  sprinkler valve drive
  alarmeSaida  out  1  latched fault indication
  estado  out  3  current FSM state code
  ciclos  out  8  count of completed irrigation cycles
REQ-003 There SHALL be one clock; reset SHALL be asynchronous and active-high.
REQ-004 All inputs SHALL be treated as synchronous to clock; no internal synchronizers.

Function
REQ-005 FSM states and codes SHALL be: OCIOSO=0, PARTIDA=1, GOTEJANDO=2, ASPERSANDO=3, PAUSA=4, FALHA=5; codes 6-7 SHALL recover to OCIOSO on the next edge.
REQ-006 Outputs SHALL be a Moore decode of registered state: bomba=1 in PARTIDA/GOTEJANDO/ASPERSANDO; valvulaGotejamento=1 only in GOTEJANDO; valvulaAspersao=1 only in ASPERSANDO; alarmeSaida=1 only in FALHA; estado=state code.
REQ-007 Timebase: prescaler (0..DIV-1) and tick timer (8 bit) SHALL both clear on every state change; the timer increments when prescaler wraps.
REQ-008 A timed state with duration T SHALL exit at the edge where prescaler=DIV-1 and timer=T-1, giving exactly T*DIV cycles of occupancy.
REQ-009 OCIOSO: alarme=1 -> FALHA; else habilita=1 and aspersao=1 -> PARTIDA, mode=aspersao; else habilita=1 and gotejamento=1 -> PARTIDA, mode=gotejamento; else stay.
REQ-010 Mode SHALL be latched on OCIOSO->PARTIDA and SHALL hold until the next OCIOSO exit; aspersao SHALL win when both requests are high.
REQ-011 PARTIDA: SHALL run T_PARTIDA ticks regardless of request changes, then go to GOTEJANDO or ASPERSANDO per latched mode.
REQ-012 GOTEJANDO/ASPERSANDO: on timer expiry -> PAUSA and ciclos increments; on requesting input (of latched mode) sampled 0, or habilita=0 -> PAUSA with no increment; a request for the other mode SHALL be ignored.
REQ-013 ciclos SHALL saturate at 255.
REQ-014 PAUSA: T_PAUSA ticks, then OCIOSO; requests ignored during PAUSA.
REQ-015 alarme=1 in any state except FALHA SHALL force FALHA on the next edge, with priority over every other transition including simultaneous timer expiry.
REQ-016 FALHA: exit to PAUSA only at an edge where alarme=0 and reconhece=1; alarme=1 with reconhece=1 SHALL stay in FALHA.

Reset
REQ-017 reset=1 SHALL immediately (asynchronously) force state=OCIOSO, prescaler=0, timer=0, mode=gotejamento, ciclos=0, all outputs 0, including mid-cycle.
REQ-018 After reset release, the first transition SHALL occur no earlier than the first rising edge with reset=0.

Verification (default parameters)
REQ-019 gotejamento=1, habilita=1 held from OCIOSO -> PARTIDA 8 cycles (bomba=1, valves 0), GOTEJANDO 40 cycles (bomba=1, valvulaGotejamento=1), PAUSA 12 cycles, OCIOSO, ciclos=1.
REQ-020 gotejamento=1 and aspersao=1 together -> ASPERSANDO after PARTIDA for 24 cycles; valvulaGotejamento stays 0 throughout.
REQ-021 alarme pulsed 1 cycle at cycle 20 of GOTEJANDO -> FALHA next edge, all drives 0, alarmeSaida=1; reconhece=1 with alarme=0 -> PAUSA, ciclos unchanged.
REQ-022 gotejamento dropped at cycle 10 of GOTEJANDO -> PAUSA next edge, ciclos unchanged; alarme rising on the same edge as timer expiry -> FALHA, ciclos unchanged.
REQ-023 reset asserted mid-ASPERSANDO between clock edges -> outputs 0 and estado=0 before the next edge; ciclos=0.
REQ-024 256 back-to-back completed cycles -> ciclos reads 255, no wrap.
